// File: rtl/ps2_scancode_ctrl.sv
// PS/2 receive path: synchroniser, frame FSM, prefix decoder and event FIFO.
// Holds the last make code for the seven-segment display decoders.
module ps2_scancode_ctrl #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [7:0] disp_code,
  output logic       frame_err,
  output logic       overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic kclk_s1_q, kclk_s2_q, kclk_h_q;
  logic kdat_s1_q, kdat_s2_q;
  logic fe, bit_in;

  state_t         state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           byte_vld_q, byte_vld_d;
  logic [7:0]     byte_q, byte_d;
  logic           err_q, err_d;

  logic           ext_q, ext_d;
  logic           brk_q, brk_d;
  logic [7:0]     disp_q, disp_d;
  logic           push;
  logic [9:0]     push_ev;

  logic [9:0]     mem_q [FIFO_DEPTH];
  logic [9:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           pop, full, wr_en;
  logic [9:0]     head;

  assign fe     = kclk_h_q & ~kclk_s2_q;
  assign bit_in = kdat_s2_q;

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    err_d      = 1'b0;
    if (state_q == S_IDLE || fe) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (fe && !bit_in) begin
          state_d  = S_DATA;
          bitcnt_d = '0;
        end
      end
      S_DATA: begin
        if (fe) begin
          shift_d  = {bit_in, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PAR;
        end
      end
      S_PAR: begin
        if (fe) begin
          par_d   = bit_in;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fe) begin
          state_d = S_IDLE;
          // odd parity over data plus parity bit
          if (bit_in && (^{shift_q, par_q})) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && !fe &&
        tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
  end

  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    disp_d  = disp_q;
    push    = 1'b0;
    push_ev = {byte_q, ext_q, brk_q};
    if (byte_vld_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!brk_q) disp_d = byte_q;
      end
    end
    if (err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  assign ev_valid = (cnt_q != '0);
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign pop      = ev_valid && ev_ready;
  assign wr_en    = push && (!full || pop);
  assign head     = ev_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_ev;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !wr_en) ovf_d = 1'b1;
    cnt_d = cnt_q + CW'(wr_en) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kclk_s1_q  <= 1'b1;
      kclk_s2_q  <= 1'b1;
      kclk_h_q   <= 1'b1;
      kdat_s1_q  <= 1'b1;
      kdat_s2_q  <= 1'b1;
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      err_q      <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      disp_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      kclk_s1_q  <= ps2_clk;
      kclk_s2_q  <= kclk_s1_q;
      kclk_h_q   <= kclk_s2_q;
      kdat_s1_q  <= ps2_data;
      kdat_s2_q  <= kdat_s1_q;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
      err_q      <= err_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      disp_q     <= disp_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ev_code   = head[9:2];
  assign ev_ext    = head[1];
  assign ev_break  = head[0];
  assign disp_code = disp_q;
  assign frame_err = err_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Random PS/2 byte streams checked against a queue-based key event model.
// Directed cases cover timeout, mid-frame reset and FIFO overflow.
module tb_ps2_scancode_ctrl;

  localparam int TMO   = 100;
  localparam int DEPTH = 4;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [7:0] disp_code;
  logic       frame_err;
  logic       overflow;

  ps2_scancode_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_break (ev_break),
    .disp_code(disp_code),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: key events as {code, ext, brk}
  logic [9:0] exp_q[$];
  logic       m_ext  = 1'b0;
  logic       m_brk  = 1'b0;
  logic [7:0] m_disp = 8'h00;
  logic       m_ovf  = 1'b0;
  int         exp_err  = 0;
  int         err_seen = 0;
  logic       prev_err = 1'b0;
  bit         hold = 1'b1;

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      exp_err++;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({b, m_ext, m_brk});
      else m_ovf = 1'b1;
      if (!m_brk) m_disp = b;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_disp = 8'h00;
    m_ovf  = 1'b0;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit good);
    logic par;
    par = good ? ~(^b) : (^b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    model_byte(b, good);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    chk("disp", 32'(disp_code), 32'(m_disp));
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !ev_valid) break;
    end
    chk("drain_q", exp_q.size(), 0);
    chk("drain_valid", 32'(ev_valid), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(ev_valid), 0);
    chk({tag, "_head"}, 32'({ev_code, ev_ext, ev_break}), 0);
    chk({tag, "_disp"}, 32'(disp_code), 0);
    chk({tag, "_err"}, 32'(frame_err), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  // consumer: random ready, compares every popped head to the model
  initial begin
    forever begin
      @(negedge clk);
      ev_ready = hold ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      if (ev_ready && ev_valid && !rst) begin
        if (exp_q.size() == 0) chk("ev_unexpected", 0, 1);
        else chk("ev", 32'({ev_code, ev_ext, ev_break}),
                 32'(exp_q.pop_front()));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (frame_err) begin
      err_seen++;
      chk("err_width", 32'(prev_err), 0);
    end
    prev_err = frame_err;
  end

  initial begin
    int n;
    logic [7:0] b;
    int r;
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    chk_zero("reset");
    rst  = 1'b0;
    hold = 1'b0;
    repeat (4) @(negedge clk);

    send(8'h1C, 1);
    send(8'hF0, 1);
    send(8'h1C, 1);
    send(8'hE0, 1);
    send(8'hF0, 1);
    send(8'h74, 1);
    send(8'hE0, 1);
    send(8'h75, 1);
    chk("disp_75", 32'(disp_code), 32'h75);
    send(8'hF0, 1);
    send(8'h1C, 0);
    chk("err_bad_par", err_seen, exp_err);
    send(8'h32, 1);
    drain();

    // stall after five data bits with an E0 pending
    send(8'hE0, 1);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    n = 0;
    for (int i = 1; i <= 250; i++) begin
      @(posedge clk);
      if (i == HALF) ps2_clk = 1'b1;
      #1;
      n = i;
      if (frame_err) break;
    end
    model_byte(8'h00, 0);
    chk("tmo_latency", n, 103);
    repeat (4) @(negedge clk);
    chk("tmo_err_cnt", err_seen, exp_err);
    send(8'h1C, 1);
    drain();

    // reset in the middle of a frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("midrst");
    repeat (300) @(negedge clk);
    chk("midrst_err", err_seen, exp_err);
    chk("midrst_valid", 32'(ev_valid), 0);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      if (b == 8'hE0 || b == 8'hF0) b = 8'h1C;
      if (r < 2)      send(8'hE0, 1);
      else if (r < 4) send(8'hF0, 1);
      else if (r < 5) send(b, 0);
      else            send(b, 1);
    end
    drain();
    chk("rand_err", err_seen, exp_err);
    chk("rand_ovf", 32'(overflow), 0);

    hold = 1'b1;
    repeat (3) @(negedge clk);
    send(8'h16, 1);
    send(8'h1E, 1);
    send(8'h26, 1);
    send(8'h25, 1);
    send(8'h2E, 1);
    repeat (10) @(negedge clk);
    chk("ovf_valid", 32'(ev_valid), 1);
    chk("ovf_flag", 32'(overflow), 32'(m_ovf));
    chk("ovf_disp", 32'(disp_code), 32'h2E);
    chk("ovf_head", 32'(ev_code), 32'h16);
    hold = 1'b0;
    drain();
    chk("ovf_sticky", 32'(overflow), 1);
    chk("final_err", err_seen, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
